// File: rtl/fx_accumulate_seq.sv
// Saturating Q7.8 add/subtract accumulator over a run of len samples, with
// valid/ready streaming input, a held result, and N/Z/V status flags.
module fx_accumulate_seq #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  N,
    output logic                  Z,
    output logic                  V
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [LEN_WIDTH-1:0]  count_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic                  op_q;
    logic                  v_q;

    logic [DATA_WIDTH:0]   ext_acc;
    logic [DATA_WIDTH:0]   ext_in;
    logic [DATA_WIDTH:0]   exact;
    logic                  sat;
    logic [DATA_WIDTH-1:0] acc_next;
    logic [LEN_WIDTH-1:0]  count_inc;
    logic                  beat;

    // One extra bit holds the exact result; a mismatch between the top two
    // bits means it fell outside the representable range.
    always_comb begin
        ext_acc   = {acc_q[DATA_WIDTH-1], acc_q};
        ext_in    = {in_data[DATA_WIDTH-1], in_data};
        exact     = op_q ? (ext_acc - ext_in) : (ext_acc + ext_in);
        sat       = exact[DATA_WIDTH] != exact[DATA_WIDTH-1];
        acc_next  = exact[DATA_WIDTH-1:0];
        if (sat) begin
            acc_next = exact[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                         : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
        count_inc = count_q + LEN_WIDTH'(1);
        beat      = (state_q == StRun) && in_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            count_q <= '0;
            len_q   <= '0;
            op_q    <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        acc_q   <= '0;
                        count_q <= '0;
                        v_q     <= 1'b0;
                        op_q    <= op;
                        len_q   <= len;
                        state_q <= (len == '0) ? StDone : StRun;
                    end
                end
                StRun: begin
                    if (beat) begin
                        acc_q   <= acc_next;
                        count_q <= count_inc;
                        if (sat) v_q <= 1'b1;
                        if (count_inc == len_q) state_q <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StRun);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign out_data  = acc_q;
    assign N         = acc_q[DATA_WIDTH-1];
    assign Z         = (acc_q == '0);
    assign V         = v_q;

endmodule
